scope_capture: RTL and testbench

Trigger-and-capture stage directly downstream of the `scope` ADC front end. It consumes the 8-bit sample stream (`oADC_Data` / `oData_Valid`) and keeps a circular pre-trigger history in block RAM. It detects a level-crossing trigger, fills the post-trigger window, then freezes the record and replays it oldest-first over a request/valid read port for the host link.

---
 rtl/scope_pkg.sv | 17 +
 rtl/scope_capture_ram.sv | 27 ++
 rtl/scope_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_scope_capture.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture path: FSM states,
// default buffer geometry and the ADC sample width.
package scope_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_PRETRIG = 128;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    DONE
  } state_e;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample buffer with a registered read port, written so
// that it maps onto a single block RAM.
module scope_capture_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              iCLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  // No reset on the read register so the block stays RAM-inferable.
  always_ff @(posedge iCLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scope_capture.sv
// Trigger-and-capture stage: circular pre-trigger history, level-crossing
// trigger, post-trigger fill and oldest-first replay. Optional macro
// SCOPE_CAPTURE_HYST_EN replaces the crossing rule with a hysteresis rule.
module scope_capture
  import scope_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PRETRIG = DEF_PRETRIG,
  parameter int HYST    = 4
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [SAMPLE_W-1:0] iADC_Data,
  input  logic                iData_Valid,
  input  logic                iArm,
  input  logic [SAMPLE_W-1:0] iTrig_Level,
  input  logic                iTrig_Rising,
  input  logic                iRd_Req,
  output logic [SAMPLE_W-1:0] oRd_Data,
  output logic                oRd_Valid,
  output logic                oRd_Last,
  output logic                oArmed,
  output logic                oTriggered,
  output logic                oDone
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(DEPTH - 1);

  if (PRETRIG < 1 || PRETRIG > DEPTH - 1 || HYST < 0 || HYST > 255) begin : g_param_check
    $error("scope_capture: PRETRIG or HYST out of range");
  end

  state_e                state_q, state_d;
  logic                  arm_q;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     trig_addr_q, trig_addr_d;
  logic [SAMPLE_W-1:0]   prev_q, prev_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                  rd_valid_q, rd_last_q, rd_last_d;
  logic                  armed_q, trig_q, done_q;
  logic                  arm_rise, fire, wr_en, rd_en;
  logic [SAMPLE_W-1:0]   ram_rd_data;

  assign arm_rise = iArm & ~arm_q;

`ifdef SCOPE_CAPTURE_HYST_EN
  localparam logic [SAMPLE_W:0] HYST_V = (SAMPLE_W+1)'(HYST);

  logic seen_q, seen_d;

  function automatic logic [SAMPLE_W-1:0] sat0_sub(input logic [SAMPLE_W-1:0] a);
    logic [SAMPLE_W:0] d;
    d = {1'b0, a} - HYST_V;
    return d[SAMPLE_W] ? '0 : d[SAMPLE_W-1:0];
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat255_add(input logic [SAMPLE_W-1:0] a);
    logic [SAMPLE_W:0] s;
    s = {1'b0, a} + HYST_V;
    return s[SAMPLE_W] ? '1 : s[SAMPLE_W-1:0];
  endfunction

  // The arming excursion must happen in ARMED before the threshold counts.
  always_comb begin
    seen_d = seen_q;
    fire   = 1'b0;
    if (state_q == ARMED && iData_Valid) begin
      if (iTrig_Rising) begin
        fire = seen_q && (iADC_Data >= iTrig_Level);
        if (iADC_Data <= sat0_sub(iTrig_Level)) seen_d = 1'b1;
      end else begin
        fire = seen_q && (iADC_Data <= iTrig_Level);
        if (iADC_Data >= sat255_add(iTrig_Level)) seen_d = 1'b1;
      end
    end
    if (state_d == ARMED && state_q != ARMED) seen_d = 1'b0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) seen_q <= 1'b0;
    else         seen_q <= seen_d;
  end
`else
  always_comb begin
    if (iTrig_Rising) fire = (prev_q < iTrig_Level) && (iADC_Data >= iTrig_Level);
    else              fire = (prev_q > iTrig_Level) && (iADC_Data <= iTrig_Level);
  end
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    prev_d      = prev_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    rd_last_d   = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    if (iData_Valid) prev_d = iADC_Data;

    case (state_q)
      IDLE: begin
        if (arm_rise) begin
          state_d  = PREFILL;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      PREFILL: begin
        if (iData_Valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == PRE_LAST) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
      end
      ARMED: begin
        if (iData_Valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fire) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = CNT_W'(1);
            state_d     = (POST_LAST == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        // cnt_q already includes the trigger sample.
        if (iData_Valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == POST_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (arm_rise) begin
          state_d  = PREFILL;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end else if (iRd_Req) begin
          rd_en     = 1'b1;
          rd_last_d = (rd_cnt_q == RD_LAST);
          if (rd_cnt_q == RD_LAST) begin
            rd_ptr_d = trig_addr_q - PRE_OFS;
            rd_cnt_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Replay starts at the oldest pre-trigger sample.
    if (state_d == DONE && state_q != DONE) begin
      rd_ptr_d = trig_addr_d - PRE_OFS;
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      prev_q      <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      armed_q     <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= iArm;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      prev_q      <= prev_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_en;
      rd_last_q   <= rd_last_d;
      armed_q     <= (state_d == ARMED);
      trig_q      <= (state_d == POST);
      done_q      <= (state_d == DONE);
    end
  end

  scope_capture_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .iCLK    (iCLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (iADC_Data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // RAM output is not resettable, so gate it with the valid flag.
  assign oRd_Data   = rd_valid_q ? ram_rd_data : '0;
  assign oRd_Valid  = rd_valid_q;
  assign oRd_Last   = rd_last_q;
  assign oArmed     = armed_q;
  assign oTriggered = trig_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture: scenario table of captures, a
// reference model of the record, and a scoreboard for the replay port.
`timescale 1ns/1ps
module tb_scope_capture;

  localparam int ADDR_W   = 9;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int PRETRIG  = 128;
  localparam int HYST     = 4;
  localparam int POST_LEN = DEPTH - PRETRIG;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iADC_Data = '0;
  logic       iData_Valid = 1'b0;
  logic       iArm = 1'b0;
  logic [7:0] iTrig_Level = '0;
  logic       iTrig_Rising = 1'b0;
  logic       iRd_Req = 1'b0;
  logic [7:0] oRd_Data;
  logic       oRd_Valid, oRd_Last, oArmed, oTriggered, oDone;

  always #5 iCLK = ~iCLK;

  scope_capture #(
    .ADDR_W  (ADDR_W),
    .PRETRIG (PRETRIG),
    .HYST    (HYST)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iADC_Data    (iADC_Data),
    .iData_Valid  (iData_Valid),
    .iArm         (iArm),
    .iTrig_Level  (iTrig_Level),
    .iTrig_Rising (iTrig_Rising),
    .iRd_Req      (iRd_Req),
    .oRd_Data     (oRd_Data),
    .oRd_Valid    (oRd_Valid),
    .oRd_Last     (oRd_Last),
    .oArmed       (oArmed),
    .oTriggered   (oTriggered),
    .oDone        (oDone)
  );

  typedef struct {
    logic [1:0] kind;     // 0 rising ramp, 1 falling ramp, 2 noise then dip
    logic       rising;
    logic [7:0] level;
    logic       toggle;   // valid 1-0-1-0
    logic [7:0] exp_pre;  // record index PRETRIG-1
    logic [7:0] exp_pt;   // record index PRETRIG (trigger sample)
  } scen_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         idx;
  } rd_exp_t;

  int checks = 0;
  int errors = 0;
  scen_t   tbl [5];
  rd_exp_t sbq [$];
  rd_exp_t mon_e;
  logic [7:0] rec [DEPTH];
  logic [7:0] got [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [7:0] gen(input logic [1:0] kind, input int k);
    case (kind)
      2'd0:    return 8'(k);
      2'd1:    return 8'(255 - (k % 256));
      default: begin
        if (k < 300)       return (k % 2 == 1) ? 8'd101 : 8'd99;
        else if (k == 300) return 8'd95;
        else               return 8'd100;
      end
    endcase
  endfunction

  always @(negedge iCLK) begin
    if (iRST_N && oRd_Valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got valid data %0h expected no valid at %0t", oRd_Data, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", {24'd0, oRd_Data}, {24'd0, mon_e.data});
        chk("rd_last", {31'd0, oRd_Last}, {31'd0, mon_e.last});
        got[mon_e.idx] = oRd_Data;
      end
    end
  end

  task automatic run_capture(input scen_t sc);
    int k = 0;
    int t = -1;
    int li;
    bit fin = 1'b0;
    bit fire;
    bit armed_e, trig_e, done_e;
    logic [7:0] d;
    logic [7:0] prevv = '0;
    logic [7:0] smp [$];
`ifdef SCOPE_CAPTURE_HYST_EN
    bit seen = 1'b0;
    int lo = (int'(sc.level) > HYST) ? int'(sc.level) - HYST : 0;
    int hi = (int'(sc.level) + HYST > 255) ? 255 : int'(sc.level) + HYST;
`endif
    iTrig_Level  = sc.level;
    iTrig_Rising = sc.rising;
    iData_Valid  = 1'b0;
    iRd_Req      = 1'b0;
    iArm         = 1'b0;
    step();
    iArm = 1'b1;
    step();
    chk("prefill_status", {29'd0, oArmed, oTriggered, oDone}, 32'd0);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      iData_Valid = sc.toggle ? (cyc % 2 == 0) : 1'b1;
      iADC_Data   = gen(sc.kind, k);
      iRd_Req     = 1'b1;
      step();
      if (iData_Valid) begin
        d = iADC_Data;
        fire = 1'b0;
        if (t < 0 && k >= PRETRIG) begin
`ifdef SCOPE_CAPTURE_HYST_EN
          if (k == PRETRIG) seen = 1'b0;
          fire = seen && (sc.rising ? (d >= sc.level) : (d <= sc.level));
          if (sc.rising ? (int'(d) <= lo) : (int'(d) >= hi)) seen = 1'b1;
`else
          fire = sc.rising ? (prevv < sc.level && d >= sc.level)
                           : (prevv > sc.level && d <= sc.level);
`endif
          if (fire) t = k;
        end
        smp.push_back(d);
        prevv = d;
        k++;
      end
      li      = k - 1;
      armed_e = (t < 0) && (li >= PRETRIG - 1);
      trig_e  = (t >= 0) && (li < t + POST_LEN - 1);
      done_e  = (t >= 0) && (li >= t + POST_LEN - 1);
      chk("armed", {31'd0, oArmed}, {31'd0, armed_e});
      chk("triggered", {31'd0, oTriggered}, {31'd0, trig_e});
      chk("done", {31'd0, oDone}, {31'd0, done_e});
      chk("rd_valid_capture", {31'd0, oRd_Valid}, 32'd0);
      fin = done_e;
    end
    iData_Valid = 1'b0;
    iRd_Req     = 1'b0;
    iArm        = 1'b0;
    if (!fin) chk("capture_timeout", 32'd0, 32'd1);
    else for (int i = 0; i < DEPTH; i++) rec[i] = smp[t - PRETRIG + i];
  endtask

  task automatic replay(input bit gaps);
    int pos = 0;
    int issued = 0;
    int guard = 0;
    while (issued < DEPTH && guard < 4 * DEPTH) begin
      iRd_Req = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iRd_Req) begin
        sbq.push_back('{data: rec[pos], last: (pos == DEPTH - 1), idx: pos});
        pos = (pos + 1) % DEPTH;
        issued++;
      end
      step();
      guard++;
    end
    iRd_Req = 1'b0;
    step();
    step();
    chk("rd_issued", issued, DEPTH);
    chk("rd_drain", sbq.size(), 32'd0);
    chk("done_hold", {31'd0, oDone}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{kind: 2'd0, rising: 1'b1, level: 8'd100, toggle: 1'b0, exp_pre: 8'd99, exp_pt: 8'd100};
    tbl[1] = '{kind: 2'd1, rising: 1'b0, level: 8'd50,  toggle: 1'b0, exp_pre: 8'd51, exp_pt: 8'd50};
    tbl[2] = '{kind: 2'd0, rising: 1'b1, level: 8'd10,  toggle: 1'b0, exp_pre: 8'd9,  exp_pt: 8'd10};
    tbl[3] = '{kind: 2'd0, rising: 1'b1, level: 8'd100, toggle: 1'b1, exp_pre: 8'd99, exp_pt: 8'd100};
`ifdef SCOPE_CAPTURE_HYST_EN
    tbl[4] = '{kind: 2'd2, rising: 1'b1, level: 8'd100, toggle: 1'b0, exp_pre: 8'd95, exp_pt: 8'd100};
`else
    tbl[4] = '{kind: 2'd2, rising: 1'b1, level: 8'd100, toggle: 1'b0, exp_pre: 8'd99, exp_pt: 8'd101};
`endif

    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_outputs", {19'd0, oRd_Data, oRd_Valid, oRd_Last, oArmed, oTriggered, oDone}, 32'd0);
    iRST_N = 1'b1;
    step();
    iRd_Req = 1'b1;
    step();
    step();
    chk("idle_rd_valid", {31'd0, oRd_Valid}, 32'd0);
    iRd_Req = 1'b0;

    for (int s = 0; s < 5; s++) begin
      run_capture(tbl[s]);
      replay(s == 3);
      chk("trig_sample", {24'd0, got[PRETRIG]}, {24'd0, tbl[s].exp_pt});
      chk("pre_sample", {24'd0, got[PRETRIG-1]}, {24'd0, tbl[s].exp_pre});
      if (s == 0) begin
        replay(1'b0);
        chk("rewrap_trig_sample", {24'd0, got[PRETRIG]}, {24'd0, tbl[s].exp_pt});
      end
    end

    // Abort a capture from POST with reset, then capture again.
    iTrig_Level  = 8'd100;
    iTrig_Rising = 1'b1;
    iArm = 1'b0;
    step();
    iArm = 1'b1;
    step();
    for (int k = 0; k < 2000 && !oTriggered; k++) begin
      iData_Valid = 1'b1;
      iADC_Data   = 8'(k);
      step();
    end
    chk("reached_post", {31'd0, oTriggered}, 32'd1);
    iData_Valid = 1'b0;
    iArm = 1'b0;
    #2 iRST_N = 1'b0;
    #1;
    chk("reset_mid_post", {19'd0, oRd_Data, oRd_Valid, oRd_Last, oArmed, oTriggered, oDone}, 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    step();
    step();
    chk("post_reset_idle", {29'd0, oArmed, oTriggered, oDone}, 32'd0);
    run_capture(tbl[0]);
    replay(1'b0);
    chk("recapture_trig_sample", {24'd0, got[PRETRIG]}, {24'd0, tbl[0].exp_pt});
    chk("recapture_pre_sample", {24'd0, got[PRETRIG-1]}, {24'd0, tbl[0].exp_pre});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
